// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the EX-stage multiply/divide sequencer:
//   - ALU control codes for DIV / DIVU / MULT / MULTU
//   - 2-bit sequencer state encoding
//   - datapath widths and small decode helpers
// Optional feature macro used by this code slice: MULDIV_MUL_PIPE_EN
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int ALUC_W = 5;

    // EX-stage ALU control codes handled by the sequencer
    localparam logic [ALUC_W-1:0] DIV_CONTROL   = 5'b11010;
    localparam logic [ALUC_W-1:0] DIVU_CONTROL  = 5'b11011;
    localparam logic [ALUC_W-1:0] MULT_CONTROL  = 5'b11000;
    localparam logic [ALUC_W-1:0] MULTU_CONTROL = 5'b11001;

    typedef enum logic [1:0] {
        MD_IDLE    = 2'b00,
        MD_DIV_RUN = 2'b01,
        MD_DONE    = 2'b10
    } md_state_e;

    // Width of a counter that must be able to hold the value 'limit'
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

    function automatic logic is_div_op(input logic [ALUC_W-1:0] code);
        return (code == DIV_CONTROL) || (code == DIVU_CONTROL);
    endfunction

    function automatic logic is_mul_op(input logic [ALUC_W-1:0] code);
        return (code == MULT_CONTROL) || (code == MULTU_CONTROL);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
// Bundles the EX-stage inputs, the external divider handshake, the hazard
// stall request and the HI/LO write port of the multiply/divide sequencer.
//   master : the surrounding pipeline / divider (drives EX and divider status)
//   slave  : muldiv_ctrl (drives divider requests, stall and HI/LO write)
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    // EX stage
    logic [ALUC_W-1:0] ex_alucontrol;
    logic [XLEN-1:0]   ex_srca;
    logic [XLEN-1:0]   ex_srcb;
    logic              ex_flush;
    logic              ex_stall;
    // external iterative divider
    logic              div_ready;
    logic [2*XLEN-1:0] div_result;
    logic              div_start;
    logic              div_signed;
    logic [XLEN-1:0]   div_opa;
    logic [XLEN-1:0]   div_opb;
    logic              div_annul;
    // hazard unit / HI-LO register file
    logic              stallreq_muldiv;
    logic              hilo_we;
    logic [2*XLEN-1:0] hilo_wdata;

    modport master (
        output ex_alucontrol, ex_srca, ex_srcb, ex_flush, ex_stall,
        output div_ready, div_result,
        input  div_start, div_signed, div_opa, div_opb, div_annul,
        input  stallreq_muldiv, hilo_we, hilo_wdata
    );

    modport slave (
        input  ex_alucontrol, ex_srca, ex_srcb, ex_flush, ex_stall,
        input  div_ready, div_result,
        output div_start, div_signed, div_opa, div_opb, div_annul,
        output stallreq_muldiv, hilo_we, hilo_wdata
    );

endinterface

// File: rtl/muldiv_ctrl_mul.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_mul
// 32x32 -> 64 signed/unsigned multiplier for MULT/MULTU.
// Macro MULDIV_MUL_PIPE_EN: when defined the product is registered (captured
// when en_i is high) and clk/rst/en_i ports exist; otherwise it is purely
// combinational.
// Ports:
//   clk, rst  : clock / async active-high reset   (pipelined build only)
//   en_i      : capture enable for the product    (pipelined build only)
//   a_i, b_i  : operands
//   signed_i  : 1 = signed (MULT), 0 = unsigned (MULTU)
//   product_o : {HI, LO}
// -----------------------------------------------------------------------------
module muldiv_ctrl_mul
    import muldiv_ctrl_pkg::*;
(
`ifdef MULDIV_MUL_PIPE_EN
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
`endif
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic              signed_i,
    output logic [2*XLEN-1:0] product_o
);

    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod_c;

    // Extending both operands to 64 bits (sign or zero) makes the low 64 bits
    // of a plain product correct for both the signed and unsigned case.
    assign a_ext  = signed_i ? {{XLEN{a_i[XLEN-1]}}, a_i} : {{XLEN{1'b0}}, a_i};
    assign b_ext  = signed_i ? {{XLEN{b_i[XLEN-1]}}, b_i} : {{XLEN{1'b0}}, b_i};
    assign prod_c = a_ext * b_ext;

`ifdef MULDIV_MUL_PIPE_EN
    logic [2*XLEN-1:0] product_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product_q <= '0;
        end else if (en_i) begin
            product_q <= prod_c;
        end
    end

    assign product_o = product_q;
`else
    assign product_o = prod_c;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// EX-stage sequencer for the shared iterative divider and the HI/LO write.
// DIV/DIVU: latches operands, holds div_start until div_ready while stalling
// the pipeline, then issues exactly one HI/LO write when the instruction
// advances. Flush or watchdog expiry annuls the divider and drops the write.
// MULT/MULTU: product from muldiv_ctrl_mul; written in the acceptance cycle,
// or one cycle later with a one-cycle stall when MULDIV_MUL_PIPE_EN is defined.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset (shared with the divider)
//   md  : muldiv_ctrl_if.slave (EX inputs, divider handshake, stall, HI/LO)
// Parameter:
//   DIV_TIMEOUT : cycles allowed in DIV_RUN before the operation is abandoned
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 40
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  md
);

    localparam int              CNT_W     = cnt_width(DIV_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DIV_TIMEOUT);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              signed_q, signed_d;
    logic [2*XLEN-1:0] hilo_q, hilo_d;
    logic              we_pend_q, we_pend_d;

    logic              div_start_c;
    logic              div_annul_c;
    logic              stallreq_c;
    logic              hilo_we_c;
    logic              accept_ok;
    logic              wd_expired;
    logic [2*XLEN-1:0] mul_product;

`ifdef MULDIV_MUL_PIPE_EN
    logic              mul_en;
    logic              is_mul_q, is_mul_d;
`else
    logic              mul_now;
`endif

    // New operations are never accepted under flush; gating with rst keeps
    // every combinational output at 0 while reset is held.
    assign accept_ok  = !rst && !md.ex_flush;
    assign wd_expired = (cnt_q == CNT_LIMIT);

    muldiv_ctrl_mul u_mul (
`ifdef MULDIV_MUL_PIPE_EN
        .clk       (clk),
        .rst       (rst),
        .en_i      (mul_en),
`endif
        .a_i       (md.ex_srca),
        .b_i       (md.ex_srcb),
        .signed_i  (md.ex_alucontrol == MULT_CONTROL),
        .product_o (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            signed_q  <= 1'b0;
            hilo_q    <= '0;
            we_pend_q <= 1'b0;
`ifdef MULDIV_MUL_PIPE_EN
            is_mul_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            signed_q  <= signed_d;
            hilo_q    <= hilo_d;
            we_pend_q <= we_pend_d;
`ifdef MULDIV_MUL_PIPE_EN
            is_mul_q  <= is_mul_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        signed_d    = signed_q;
        hilo_d      = hilo_q;
        we_pend_d   = we_pend_q;
        div_start_c = 1'b0;
        div_annul_c = 1'b0;
        stallreq_c  = 1'b0;
        hilo_we_c   = 1'b0;
`ifdef MULDIV_MUL_PIPE_EN
        mul_en      = 1'b0;
        is_mul_d    = is_mul_q;
`else
        mul_now     = 1'b0;
`endif

        case (state_q)
            MD_IDLE: begin
                cnt_d = '0;
                if (accept_ok && is_div_op(md.ex_alucontrol)) begin
                    if (md.ex_srcb != '0) begin
                        opa_d      = md.ex_srca;
                        opb_d      = md.ex_srcb;
                        signed_d   = (md.ex_alucontrol == DIV_CONTROL);
                        stallreq_c = 1'b1;
                        state_d    = MD_DIV_RUN;
                    end else begin
                        // Divide by zero: no divider activity, HI/LO left
                        // untouched; DONE only waits for the instruction to
                        // advance so it is not re-decoded while held in EX.
                        we_pend_d = 1'b0;
                        state_d   = MD_DONE;
                    end
                end else if (accept_ok && is_mul_op(md.ex_alucontrol)) begin
`ifdef MULDIV_MUL_PIPE_EN
                    mul_en     = 1'b1;
                    is_mul_d   = 1'b1;
                    we_pend_d  = 1'b1;
                    stallreq_c = 1'b1;
                    state_d    = MD_DONE;
`else
                    // Combinational product: write whenever EX may advance;
                    // a held MULT simply re-presents the same product.
                    mul_now   = 1'b1;
                    hilo_we_c = !md.ex_stall;
`endif
                end
            end

            MD_DIV_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (md.ex_flush || wd_expired) begin
                    // A div_ready in this cycle is deliberately dropped.
                    div_annul_c = 1'b1;
                    cnt_d       = '0;
                    state_d     = MD_IDLE;
                end else begin
                    stallreq_c  = 1'b1;
                    div_start_c = !md.div_ready;
                    if (md.div_ready) begin
                        hilo_d    = {md.div_result[2*XLEN-1:XLEN], md.div_result[XLEN-1:0]};
                        we_pend_d = 1'b1;
`ifdef MULDIV_MUL_PIPE_EN
                        is_mul_d  = 1'b0;
`endif
                        cnt_d     = '0;
                        state_d   = MD_DONE;
                    end
                end
            end

            MD_DONE: begin
                // Leaving on the first un-stalled cycle guarantees a single
                // write and no re-start while the instruction is still in EX.
                if (md.ex_flush) begin
                    we_pend_d = 1'b0;
                    state_d   = MD_IDLE;
                end else if (!md.ex_stall) begin
                    hilo_we_c = we_pend_q;
                    we_pend_d = 1'b0;
                    state_d   = MD_IDLE;
                end
            end

            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    assign md.div_start       = div_start_c;
    assign md.div_annul       = div_annul_c;
    assign md.div_signed      = signed_q;
    assign md.div_opa         = opa_q;
    assign md.div_opb         = opb_q;
    assign md.stallreq_muldiv = stallreq_c;
    assign md.hilo_we         = hilo_we_c;

`ifdef MULDIV_MUL_PIPE_EN
    assign md.hilo_wdata = is_mul_q ? mul_product : hilo_q;
`else
    assign md.hilo_wdata = mul_now ? mul_product : hilo_q;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed + randomized bench for muldiv_ctrl. The external divider is
// emulated here; expected HI/LO values come from plain SV arithmetic on the
// operands the bench presented in EX.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.DIV_TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    task automatic chk(input string tag, input string what,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1ns after the edge and outputs
    // are sampled 2ns later, well clear of both clock edges.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        int          sq, sr;
        int unsigned uq, ur;
        if (sgn) begin
            sq = int'(a) / int'(b);
            sr = int'(a) % int'(b);
            return {32'(sr), 32'(sq)};
        end
        uq = a / b;
        ur = a % b;
        return {32'(ur), 32'(uq)};
    endfunction

    function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'(a);
        ub = longint'(b);
        return sgn ? 64'(sa * sb) : 64'(ua * ub);
    endfunction

    task automatic set_ex(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic fl, input logic st);
        bus.ex_alucontrol = op;
        bus.ex_srca       = a;
        bus.ex_srcb       = b;
        bus.ex_flush      = fl;
        bus.ex_stall      = st;
    endtask

    // One divide instruction from acceptance to the cycle it advances.
    // lat : DIV_RUN cycle in which the emulated divider raises div_ready
    // hold: extra cycles EX is held by an external stall once the result is in
    task automatic do_div(input string tag, input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input int hold,
                          input logic [63:0] exp);
        logic sgn;
        sgn = (code == DIV_CONTROL);
        cyc();
        set_ex(code, a, b, 1'b0, 1'b0);
        bus.div_ready = 1'b0;
        settle();
        chk(tag, "acc_stall", bus.stallreq_muldiv, b != 0);
        chk(tag, "acc_start", bus.div_start, 0);
        chk(tag, "acc_we", bus.hilo_we, 0);
        if (b != 0) begin
            for (int k = 1; k <= lat; k++) begin
                cyc();
                bus.div_ready  = (k == lat);
                bus.div_result = (k == lat) ? div_ref(bus.div_signed, bus.div_opa, bus.div_opb)
                                            : 64'h0;
                settle();
                chk(tag, "run_stall", bus.stallreq_muldiv, 1);
                chk(tag, "run_start", bus.div_start, k != lat);
                if (k == 1) begin
                    chk(tag, "signed", bus.div_signed, sgn);
                    chk(tag, "opa", bus.div_opa, a);
                    chk(tag, "opb", bus.div_opb, b);
                end
            end
        end
        for (int h = 0; h < hold; h++) begin
            cyc();
            bus.div_ready = 1'b0;
            bus.ex_stall  = 1'b1;
            settle();
            chk(tag, "hold_stall", bus.stallreq_muldiv, 0);
            chk(tag, "hold_start", bus.div_start, 0);
            chk(tag, "hold_we", bus.hilo_we, 0);
        end
        cyc();
        bus.div_ready = 1'b0;
        bus.ex_stall  = 1'b0;
        settle();
        chk(tag, "done_we", bus.hilo_we, b != 0);
        if (b != 0) chk(tag, "done_wdata", bus.hilo_wdata, exp);
        chk(tag, "done_stall", bus.stallreq_muldiv, 0);
        chk(tag, "done_start", bus.div_start, 0);
    endtask

    // One multiply; st = cycles EX is held before the instruction can advance
    task automatic do_mul(input string tag, input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input int st, input logic [63:0] exp);
`ifdef MULDIV_MUL_PIPE_EN
        cyc();
        set_ex(code, a, b, 1'b0, 1'b0);
        settle();
        chk(tag, "acc_stall", bus.stallreq_muldiv, 1);
        chk(tag, "acc_we", bus.hilo_we, 0);
        cyc();
        settle();
        chk(tag, "we", bus.hilo_we, 1);
        chk(tag, "wdata", bus.hilo_wdata, exp);
        chk(tag, "stall", bus.stallreq_muldiv, 0);
`else
        for (int s = 0; s < st; s++) begin
            cyc();
            set_ex(code, a, b, 1'b0, 1'b1);
            settle();
            chk(tag, "held_we", bus.hilo_we, 0);
            chk(tag, "held_stall", bus.stallreq_muldiv, 0);
        end
        cyc();
        set_ex(code, a, b, 1'b0, 1'b0);
        settle();
        chk(tag, "we", bus.hilo_we, 1);
        chk(tag, "wdata", bus.hilo_wdata, exp);
        chk(tag, "stall", bus.stallreq_muldiv, 0);
`endif
        chk(tag, "start", bus.div_start, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [4:0]  code;
        logic [31:0] ra, rb;

        // ---------------- reset ----------------
        rst = 1'b1;
        set_ex(MULT_CONTROL, 32'd3, 32'd5, 1'b0, 1'b0);
        bus.div_ready  = 1'b0;
        bus.div_result = 64'h0;
        repeat (2) @(posedge clk);
        #3;
        chk("reset", "stall", bus.stallreq_muldiv, 0);
        chk("reset", "start", bus.div_start, 0);
        chk("reset", "annul", bus.div_annul, 0);
        chk("reset", "we", bus.hilo_we, 0);
        chk("reset", "wdata", bus.hilo_wdata, 0);
        chk("reset", "opa", bus.div_opa, 0);
        chk("reset", "signed", bus.div_signed, 0);
        cyc();
        rst = 1'b0;
        set_ex(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        settle();
        chk("post_reset", "stall", bus.stallreq_muldiv, 0);

        // ---------------- directed divides ----------------
        do_div("div_100_m7", DIV_CONTROL, 32'd100, 32'hFFFF_FFF9, 33, 0, 64'h00000002_FFFFFFF2);
        do_div("divu_max_16", DIVU_CONTROL, 32'hFFFF_FFFF, 32'h10, 5, 0, 64'h0000000F_0FFFFFFF);
        do_div("div_by_zero", DIV_CONTROL, 32'd77, 32'd0, 0, 1, 64'h0);
        do_div("div_held", DIV_CONTROL, 32'hFFFF_FFCE, 32'd6, 4, 3,
               div_ref(1'b1, 32'hFFFF_FFCE, 32'd6));

        // ---------------- flush in DIV_RUN at cycle 10 ----------------
        cyc();
        set_ex(DIV_CONTROL, 32'd1000, 32'd3, 1'b0, 1'b0);
        settle();
        chk("flush_run", "acc_stall", bus.stallreq_muldiv, 1);
        for (int k = 1; k < 10; k++) begin
            cyc();
            settle();
            chk("flush_run", "pre_annul", bus.div_annul, 0);
        end
        cyc();
        bus.ex_flush = 1'b1;
        settle();
        chk("flush_run", "annul", bus.div_annul, 1);
        chk("flush_run", "stall", bus.stallreq_muldiv, 0);
        chk("flush_run", "start", bus.div_start, 0);
        chk("flush_run", "we", bus.hilo_we, 0);
        cyc();
        set_ex(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        settle();
        chk("flush_run", "annul_once", bus.div_annul, 0);
        chk("flush_run", "idle_start", bus.div_start, 0);
        cyc();
        bus.div_ready  = 1'b1;
        bus.div_result = 64'h1234_5678_9ABC_DEF0;
        settle();
        chk("flush_run", "late_ready_we", bus.hilo_we, 0);
        cyc();
        bus.div_ready = 1'b0;
        settle();
        chk("flush_run", "late_ready_we2", bus.hilo_we, 0);

        // ---------------- multiplies ----------------
        do_mul("mult_m2_3", MULT_CONTROL, 32'hFFFF_FFFE, 32'd3, 2, 64'hFFFFFFFF_FFFFFFFA);
        do_mul("multu_m2_3", MULTU_CONTROL, 32'hFFFF_FFFE, 32'd3, 0, 64'h00000002_FFFFFFFA);

        // ---------------- flush while IDLE: not accepted ----------------
        cyc();
        set_ex(DIV_CONTROL, 32'd40, 32'd5, 1'b1, 1'b0);
        settle();
        chk("flush_idle", "stall", bus.stallreq_muldiv, 0);
        cyc();
        set_ex(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        settle();
        chk("flush_idle", "start", bus.div_start, 0);

        // ---------------- flush while DONE: write suppressed ----------------
        cyc();
        set_ex(DIVU_CONTROL, 32'd50, 32'd7, 1'b0, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            cyc();
            bus.div_ready  = (k == 2);
            bus.div_result = div_ref(bus.div_signed, bus.div_opa, bus.div_opb);
        end
        cyc();
        bus.div_ready = 1'b0;
        bus.ex_stall  = 1'b1;
        bus.ex_flush  = 1'b1;
        settle();
        chk("flush_done", "we", bus.hilo_we, 0);
        cyc();
        set_ex(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        settle();
        chk("flush_done", "we_after", bus.hilo_we, 0);
        chk("flush_done", "start_after", bus.div_start, 0);

        // ---------------- watchdog: divider never answers ----------------
        // The operation is abandoned once DIV_TIMEOUT full cycles have been
        // spent in DIV_RUN, i.e. in its (DIV_TIMEOUT+1)-th DIV_RUN cycle.
        cyc();
        set_ex(DIV_CONTROL, 32'd7, 32'd2, 1'b0, 1'b0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            cyc();
            settle();
            chk("watchdog", "no_annul", bus.div_annul, 0);
        end
        cyc();
        settle();
        chk("watchdog", "annul", bus.div_annul, 1);
        chk("watchdog", "stall", bus.stallreq_muldiv, 0);
        chk("watchdog", "start", bus.div_start, 0);
        cyc();
        set_ex(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        settle();
        chk("watchdog", "we_after", bus.hilo_we, 0);
        chk("watchdog", "annul_once", bus.div_annul, 0);

        // ---------------- reset in the middle of a divide ----------------
        cyc();
        set_ex(DIV_CONTROL, 32'd9, 32'd4, 1'b0, 1'b0);
        repeat (3) cyc();
        rst = 1'b1;
        settle();
        chk("mid_reset", "start", bus.div_start, 0);
        chk("mid_reset", "stall", bus.stallreq_muldiv, 0);
        chk("mid_reset", "annul", bus.div_annul, 0);
        chk("mid_reset", "opa", bus.div_opa, 0);
        chk("mid_reset", "wdata", bus.hilo_wdata, 0);
        cyc();
        rst = 1'b0;
        set_ex(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        settle();
        chk("mid_reset", "idle_start", bus.div_start, 0);

        // ---------------- randomized back-to-back traffic ----------------
        for (int i = 0; i < 8; i++) begin
            code = ($urandom_range(0, 1) == 0) ? DIV_CONTROL : DIVU_CONTROL;
            ra   = $urandom;
            rb   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (rb == 0) rb = 32'd1;
            if (code == DIV_CONTROL && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            do_div("rand_div", code, ra, rb, $urandom_range(1, 20), $urandom_range(0, 2),
                   div_ref(code == DIV_CONTROL, ra, rb));
        end
        for (int i = 0; i < 6; i++) begin
            code = ($urandom_range(0, 1) == 0) ? MULT_CONTROL : MULTU_CONTROL;
            ra   = $urandom;
            rb   = $urandom;
            do_mul("rand_mul", code, ra, rb, $urandom_range(0, 2),
                   mul_ref(code == MULT_CONTROL, ra, rb));
        end

        cyc();
        set_ex(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        settle();
        chk("final", "we", bus.hilo_we, 0);
        chk("final", "stall", bus.stallreq_muldiv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the shared multi-cycle divider and the HI/LO write path in the EX stage.
- Detects DIV/DIVU/MULT/MULTU in EX and drives the iterative divider's start/annul handshake.
- Raises a stall request to the hazard unit until the result is ready, then issues exactly one HI/LO write per instruction.
- Handles flush and pipeline stall while an operation is in flight.

Parameters:
- DIV_TIMEOUT, 40, watchdog cycle count in DIV_RUN; on expiry the operation is abandoned as if annulled.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ex_alucontrol  in  5  EX-stage ALU control code (DIV/DIVU/MULT/MULTU codes from defines.vh)
- ex_srca  in  32  rs operand
- ex_srcb  in  32  rt operand
- ex_flush  in  1  EX flush (exception / load-use bubble)
- ex_stall  in  1  EX held by external stall (mem stall)
- div_ready  in  1  divider result valid (level)
- div_result  in  64  {remainder, quotient} from divider
- div_start  out  1  level request to divider, held until div_ready
- div_signed  out  1  1 for DIV, 0 for DIVU
- div_opa  out  32  latched dividend
- div_opb  out  32  latched divisor
- div_annul  out  1  one-cycle pulse cancelling the divider
- stallreq_muldiv  out  1  stall request to hazard unit
- hilo_we  out  1  one-cycle HI/LO write enable
- hilo_wdata  out  64  {HI, LO}

Behaviour:
- Reset: all outputs 0, state IDLE, watchdog counter 0.
- States: IDLE, DIV_RUN, DONE.
- IDLE, DIV/DIVU, ex_flush=0, divisor != 0:
  - latch operands and sign; go to DIV_RUN.
  - stallreq_muldiv=1 combinationally in the same cycle.
- IDLE, DIV/DIVU, divisor == 0:
  - no divider activity, no stall, hilo_we=0 (HI/LO unchanged); go to DONE.
- DIV_RUN:
  - div_start=1, stallreq_muldiv=1, counter increments.
  - When div_ready=1: capture hilo_wdata = {div_result[63:32], div_result[31:0]}, drop div_start, go to DONE.
- DONE:
  - stallreq_muldiv=0.
  - hilo_we pulses 1 in the first DONE cycle with ex_stall=0, then never again for this instruction.
  - Leave to IDLE on the first cycle with ex_stall=0 (the instruction advances).
  - While ex_stall=1, remain in DONE and do not restart, even though ex_alucontrol still shows DIV.
- Flush in DIV_RUN: div_annul=1 for one cycle, div_start=0, stallreq=0, hilo_we never asserted; go to IDLE.
  - A div_ready arriving in the same cycle is ignored.
- Flush in DONE: suppress any pending hilo_we; go to IDLE.
- Flush in IDLE: the new operation is not accepted.
- Watchdog: counter reaching DIV_TIMEOUT in DIV_RUN behaves as a flush (annul, no write).
- MULT/MULTU (IDLE, no flush):
  - signed or unsigned 32x32 -> 64 product into hilo_wdata.
  - Latency per the optional feature.
- Reset asserted mid-operation: immediate return to IDLE, outputs 0; no annul pulse (the divider resets from the same rst).
- Back-to-back DIVs: the second is accepted only after DONE -> IDLE, i.e. the cycle after the first advances.

Optional Feature:
- Macro: MULDIV_MUL_PIPE_EN.
- Defined:
  - product registered; MULT enters DONE one cycle later.
  - stallreq_muldiv=1 for exactly one cycle.
  - hilo_we in the cycle after acceptance.
- Undefined:
  - product combinational; hilo_we=1 in the acceptance cycle when ex_stall=0.
  - No stall; no state change.

Decomposition:
- defines.vh (shared):
  - DIV_CONTROL, DIVU_CONTROL, MULT_CONTROL, MULTU_CONTROL.
  - MULDIV state encodings (2-bit).
- Local: watchdog counter width derived from DIV_TIMEOUT.
- Sub-module: muldiv_mul (signed/unsigned multiplier, optional output register under MULDIV_MUL_PIPE_EN).
- The divider stays external.

Test Plan:
- DIV 100 / -7, divider ready after 33 cycles:
  - stallreq high for cycles 0..33, div_signed=1.
  - A single hilo_we with HI=0x00000002, LO=0xFFFFFFF2.
- DIVU 0xFFFFFFFF / 0x10:
  - HI=0x0000000F, LO=0x0FFFFFFF.
  - div_start held until div_ready, then low.
- DIV with ex_flush at cycle 10 of DIV_RUN:
  - div_annul pulse at cycle 10, stallreq drops, hilo_we never asserted.
  - A later div_ready is ignored.
- Divisor 0:
  - no stall, no div_start, no hilo_we.
- div_ready while ex_stall=1 for 3 cycles:
  - stallreq drops, one hilo_we only.
  - No second div_start while DIV remains in EX.
- MULT -2 x 3:
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Zero-cycle stall without MULDIV_MUL_PIPE_EN, one-cycle stall with it.
